// File: rtl/imem_uart_loader.sv
// ---------------------------------------------------------------------------
// imem_uart_loader
//   Receives a program image from a UART byte stream and writes it into
//   instruction memory, holding the CPU in reset while loading.
//   Image format: 4-byte word count N (always MSB first), then N words of
//   4 bytes each, packed according to BIG_ENDIAN.
//
// Parameters
//   ADDR_W     instruction-memory word-address width (MAX_WORDS = 2**ADDR_W)
//   BIG_ENDIAN 1: first byte of a word -> [31:24]; 0: first byte -> [7:0]
//   TIMEOUT    idle cycles allowed between accepted bytes before abort
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               load-mode request level
//   rx_valid/rx_data    incoming UART byte
//   rx_ready            byte accepted when rx_valid & rx_ready at a clock edge
//   imem_we/addr/wdata  one-cycle write strobe per assembled word
//   cpu_hold            holds fetch stage in reset while loading
//   done, error         load completed / aborted (error sticky until restart)
//   word_count          words written in the current or last load
// ---------------------------------------------------------------------------
module imem_uart_loader #(
    parameter int ADDR_W     = 14,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int TIMEOUT    = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int             TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [32:0]    MAX_WORDS = 33'(1) << ADDR_W;
    localparam logic [ADDR_W:0] WC_ONE   = 1;
    localparam logic [TMO_W-1:0] TMO_ONE = 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [31:0]      len;
    logic [31:0]      word;
    logic [1:0]       byte_cnt;
    logic [TMO_W-1:0] tmo;

    logic             accept;
    logic [31:0]      len_next;
    logic [31:0]      word_next;
    logic             len_bad;
    logic             tmo_hit;
    logic [ADDR_W:0]  wc_next;
    logic             last_word;

    assign accept    = rx_valid & rx_ready;
    // The length field is always MSB first, independent of BIG_ENDIAN.
    assign len_next  = {len[23:0], rx_data};
    assign word_next = BIG_ENDIAN ? {word[23:0], rx_data} : {rx_data, word[31:8]};
    // Full 33-bit compare so oversize counts are never aliased into range.
    assign len_bad   = (len_next == 32'd0) || ({1'b0, len_next} > MAX_WORDS);
    assign tmo_hit   = (tmo == TMO_LAST);
    assign wc_next   = word_count + WC_ONE;
    assign last_word = (32'(wc_next) == len);

    // NOTE: all state and outputs are registers updated with non-blocking
    // assignments; the asynchronous reset clears them without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            len        <= '0;
            word       <= '0;
            byte_cnt   <= '0;
            tmo        <= '0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            // Write strobe is a single-cycle pulse; only the DATA->WRITE
            // transition raises it.
            imem_we <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LEN;
                        cpu_hold   <= 1'b1;
                        rx_ready   <= 1'b1;
                        len        <= '0;
                        byte_cnt   <= '0;
                        tmo        <= '0;
                        word_count <= '0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end

                S_LEN, S_DATA: begin
                    if (!start) begin
                        state    <= S_ERR;
                        rx_ready <= 1'b0;
                        error    <= 1'b1;
                    end else if (accept) begin
                        tmo      <= '0;
                        byte_cnt <= byte_cnt + 2'd1;  // wraps to 0 after 4 bytes
                        if (state == S_LEN) begin
                            len <= len_next;
                            if (byte_cnt == 2'd3) begin
                                if (len_bad) begin
                                    state    <= S_ERR;
                                    rx_ready <= 1'b0;
                                    error    <= 1'b1;
                                end else begin
                                    state <= S_DATA;
                                end
                            end
                        end else begin
                            word <= word_next;
                            if (byte_cnt == 2'd3) begin
                                state      <= S_WRITE;
                                rx_ready   <= 1'b0;
                                imem_we    <= 1'b1;
                                imem_addr  <= word_count[ADDR_W-1:0];
                                imem_wdata <= word_next;
                            end
                        end
                    end else if (tmo_hit) begin
                        state    <= S_ERR;
                        rx_ready <= 1'b0;
                        error    <= 1'b1;
                    end else begin
                        tmo <= tmo + TMO_ONE;
                    end
                end

                // The write is already on the bus this cycle; an abort only
                // takes effect once it has completed.
                S_WRITE: begin
                    word_count <= wc_next;
                    if (!start) begin
                        state <= S_ERR;
                        error <= 1'b1;
                    end else if (last_word) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_DATA;
                        rx_ready <= 1'b1;
                    end
                end

                // done/error deliberately survive the return to IDLE.
                S_DONE, S_ERR: begin
                    if (!start) begin
                        state    <= S_IDLE;
                        cpu_hold <= 1'b0;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    rx_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule
